// File: rtl/sr_fetch.sv
// Instruction fetch stage: issues one word-aligned request at a time to instruction memory
// and buffers returned words in a small FIFO for decode, with branch redirect and flush.
module sr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        pcSrc,
    input  logic [31:0] pcBranch,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] STALE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [31:0]      fetchPc;
    logic [31:0]      reqPc;
    logic [31:0]      pcMem   [FIFO_DEPTH];
    logic [31:0]      dataMem [FIFO_DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancyNext;
    logic             push;
    logic             pop;
    logic             accept;

    assign instr_valid = !rst && (count != '0);
    assign instr       = instr_valid ? dataMem[headPtr] : 32'h0;
    assign instr_pc    = instr_valid ? pcMem[headPtr]   : 32'h0;
    assign imem_addr   = fetchPc;

    assign pop  = instr_valid && instr_ready;
    assign push = imem_rsp_valid && (state == WAIT) && !pcSrc;

    // A new request is only issued if its eventual response is guaranteed a FIFO slot.
    assign occupancyNext  = (CNT_W+1)'(count) + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
    assign imem_req_valid = !rst && ((state == IDLE) || imem_rsp_valid)
                            && (occupancyNext < (CNT_W+1)'(FIFO_DEPTH));
    assign accept         = imem_req_valid && imem_req_ready;

    always_comb begin
        stateNext = state;
        if (state != IDLE && state != WAIT && state != STALE) begin
            stateNext = IDLE;
        end else if (state == IDLE || imem_rsp_valid) begin
            if (accept) begin
                stateNext = pcSrc ? STALE : WAIT;
            end else begin
                stateNext = IDLE;
            end
        end else if (state == WAIT && pcSrc) begin
            stateNext = STALE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            reqPc   <= RESET_PC;
        end else begin
            state <= stateNext;
            if (accept) begin
                reqPc <= fetchPc;
            end
            if (pcSrc) begin
                fetchPc <= {pcBranch[31:2], 2'b00};
            end else if (accept) begin
                fetchPc <= fetchPc + 32'd4;
            end
        end
    end

    // A redirect flushes everything, including the entry popped in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || pcSrc) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            count <= occupancyNext[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[tailPtr]   <= reqPc;
            dataMem[tailPtr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_sr_fetch.sv
// Testbench for sr_fetch: a directed cycle table for the fetch/stall/redirect corner cases,
// then a randomized run against a reference PC model and a one-outstanding memory model.
module tb_sr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        pcSrc = 1'b0;
    logic [31:0] pcBranch = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    sr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pcSrc          (pcSrc),
        .pcBranch       (pcBranch),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic        rst;
        logic        reqReady;
        logic        rspValid;
        logic [31:0] rspAddr;
        logic        pcSrc;
        logic [31:0] pcBranch;
        logic        instrReady;
        logic        expReqValid;
        logic [31:0] expAddr;
        logic        expInstrValid;
        logic [31:0] expInstrPc;
    } vectorT;

    vectorT vectors[$];

    function automatic logic [31:0] dataOf(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    function automatic vectorT mk(input logic [31:0] r, input logic [31:0] rdy,
                                  input logic [31:0] rspV, input logic [31:0] rspA,
                                  input logic [31:0] br, input logic [31:0] brTarget,
                                  input logic [31:0] iRdy, input logic [31:0] eReqV,
                                  input logic [31:0] eAddr, input logic [31:0] eIV,
                                  input logic [31:0] eIPc);
        vectorT v;
        v.rst           = r[0];
        v.reqReady      = rdy[0];
        v.rspValid      = rspV[0];
        v.rspAddr       = rspA;
        v.pcSrc         = br[0];
        v.pcBranch      = brTarget;
        v.instrReady    = iRdy[0];
        v.expReqValid   = eReqV[0];
        v.expAddr       = eAddr;
        v.expInstrValid = eIV[0];
        v.expInstrPc    = eIPc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vectorT v);
        rst            = v.rst;
        imem_req_ready = v.reqReady;
        imem_rsp_valid = v.rspValid;
        imem_rsp_data  = dataOf(v.rspAddr);
        pcSrc          = v.pcSrc;
        pcBranch       = v.pcBranch;
        instr_ready    = v.instrReady;
    endtask

    task automatic checkRow(input int idx, input vectorT v);
        checkOutput($sformatf("row%0d reqValid", idx), 32'(imem_req_valid), 32'(v.expReqValid));
        if (v.expReqValid) begin
            checkOutput($sformatf("row%0d imemAddr", idx), imem_addr, v.expAddr);
        end
        checkOutput($sformatf("row%0d instrValid", idx), 32'(instr_valid), 32'(v.expInstrValid));
        if (v.expInstrValid) begin
            checkOutput($sformatf("row%0d instrPc", idx), instr_pc, v.expInstrPc);
            checkOutput($sformatf("row%0d instr", idx), instr, dataOf(v.expInstrPc));
        end else if (v.rst) begin
            checkOutput($sformatf("row%0d instrPcRst", idx), instr_pc, 32'h0);
            checkOutput($sformatf("row%0d instrRst", idx), instr, 32'h0);
        end
    endtask

    // Memory model and reference PC model for the randomized phase.
    bit          memBusy;
    logic [31:0] memAddr;
    int          memDelay;
    logic [31:0] expPc;
    bit          prevHold;
    logic [31:0] prevPc;
    int          pops;

    initial begin
        //        rst rdy rspV rspAddr        pcSrc pcBranch        iRdy  reqV addr           IV IPc
        vectors.push_back(mk(1, 1, 0, 0,              0, 0,              1,  0, 0,              0, 0));
        vectors.push_back(mk(1, 1, 0, 0,              0, 0,              1,  0, 0,              0, 0));
        vectors.push_back(mk(0, 1, 0, 0,              0, 0,              1,  1, 0,              0, 0));
        vectors.push_back(mk(0, 1, 1, 0,              0, 0,              1,  1, 4,              0, 0));
        vectors.push_back(mk(0, 1, 1, 4,              0, 0,              1,  1, 8,              1, 0));
        vectors.push_back(mk(0, 1, 1, 8,              0, 0,              1,  1, 12,             1, 4));
        vectors.push_back(mk(0, 1, 1, 12,             0, 0,              1,  1, 16,             1, 8));
        vectors.push_back(mk(1, 1, 1, 16,             0, 0,              1,  0, 0,              0, 0));
        vectors.push_back(mk(0, 1, 0, 0,              0, 0,              0,  1, 0,              0, 0));
        vectors.push_back(mk(0, 1, 1, 0,              0, 0,              0,  1, 4,              0, 0));
        vectors.push_back(mk(0, 1, 1, 4,              0, 0,              0,  0, 0,              1, 0));
        vectors.push_back(mk(0, 1, 0, 0,              0, 0,              0,  0, 0,              1, 0));
        vectors.push_back(mk(0, 1, 0, 0,              0, 0,              0,  0, 0,              1, 0));
        vectors.push_back(mk(0, 1, 0, 0,              0, 0,              0,  0, 0,              1, 0));
        vectors.push_back(mk(0, 1, 0, 0,              0, 0,              1,  1, 8,              1, 0));
        vectors.push_back(mk(0, 1, 1, 8,              0, 0,              1,  1, 12,             1, 4));
        vectors.push_back(mk(0, 1, 1, 12,             0, 0,              1,  1, 16,             1, 8));
        vectors.push_back(mk(0, 1, 0, 0,              1, 'h103,          1,  0, 0,              1, 12));
        vectors.push_back(mk(0, 1, 1, 16,             0, 0,              1,  1, 'h100,          0, 0));
        vectors.push_back(mk(0, 1, 1, 'h100,          0, 0,              1,  1, 'h104,          0, 0));
        vectors.push_back(mk(0, 1, 1, 'h104,          0, 0,              1,  1, 'h108,          1, 'h100));
        vectors.push_back(mk(0, 1, 1, 'h108,          1, 32'hFFFF_FFFE,  1,  1, 'h10C,          1, 'h104));
        vectors.push_back(mk(0, 1, 1, 'h10C,          0, 0,              1,  1, 32'hFFFF_FFFC,  0, 0));
        vectors.push_back(mk(0, 1, 1, 32'hFFFF_FFFC,  0, 0,              1,  1, 0,              0, 0));
        vectors.push_back(mk(0, 1, 1, 0,              0, 0,              1,  1, 4,              1, 32'hFFFF_FFFC));
        vectors.push_back(mk(0, 1, 1, 4,              0, 0,              1,  1, 8,              1, 0));
        vectors.push_back(mk(0, 0, 1, 8,              0, 0,              1,  1, 12,             1, 4));
        vectors.push_back(mk(0, 0, 1, 32'hDEAD_BEE0,  0, 0,              1,  1, 12,             1, 8));
        vectors.push_back(mk(0, 0, 0, 0,              0, 0,              1,  1, 12,             0, 0));
        vectors.push_back(mk(0, 1, 0, 0,              0, 0,              1,  1, 12,             0, 0));
        vectors.push_back(mk(0, 1, 1, 12,             0, 0,              1,  1, 16,             0, 0));
        vectors.push_back(mk(0, 1, 1, 16,             0, 0,              1,  1, 20,             1, 12));

        for (int i = 0; i < vectors.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vectors[i]);
            @(negedge clk);
            checkRow(i, vectors[i]);
        end

        // Randomized traffic: variable memory latency, back-pressure and redirects.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            rst            = 1'b1;
            imem_rsp_valid = 1'b0;
            pcSrc          = 1'b0;
        end
        memBusy  = 1'b0;
        memAddr  = 32'h0;
        memDelay = 0;
        expPc    = 32'h0000_0000;
        prevHold = 1'b0;
        prevPc   = 32'h0;
        pops     = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            #1;
            rst            = 1'b0;
            imem_rsp_valid = 1'b0;
            if (memBusy) begin
                memDelay--;
                if (memDelay == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = dataOf(memAddr);
                    memBusy        = 1'b0;
                end
            end
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            pcSrc          = ($urandom_range(0, 11) == 0);
            pcBranch       = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                         : $urandom;
            @(negedge clk);
            if (prevHold) begin
                checkOutput("holdPc", instr_pc, prevPc);
            end
            if (instr_valid && instr_ready) begin
                checkOutput("randInstrPc", instr_pc, expPc);
                checkOutput("randInstr", instr, dataOf(expPc));
                expPc = expPc + 32'd4;
                pops++;
            end
            if (pcSrc) begin
                expPc = {pcBranch[31:2], 2'b00};
            end
            if (imem_req_valid && imem_req_ready) begin
                checkOutput("singleOutstanding", 32'(memBusy), 32'h0);
                memBusy  = 1'b1;
                memAddr  = imem_addr;
                memDelay = $urandom_range(1, 5);
            end
            prevHold = instr_valid && !instr_ready && !pcSrc;
            prevPc   = instr_pc;
        end
        checkOutput("randProgress", 32'(pops > 20), 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sr_fetch.md
SR_FETCH -- requirements
Module: sr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1: the one clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port imem_req_valid  output  1: fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1: memory accepts the request this cycle.
REQ-007 SHALL have port imem_addr  output  32: fetch address, word aligned.
REQ-008 SHALL have port imem_rsp_valid  input  1: response valid; arrives >= 1 cycle after acceptance, in order.
REQ-009 SHALL have port imem_rsp_data  input  32: fetched instruction word.
REQ-010 SHALL have port pcSrc  input  1: branch-taken redirect from the control stage.
REQ-011 SHALL have port pcBranch  input  32: redirect target.
REQ-012 SHALL have port instr_valid  output  1: buffer head valid, to the decode/control stage.
REQ-013 SHALL have port instr_ready  input  1: decode consumes the head this cycle.
REQ-014 SHALL have port instr  output  32: head instruction word.
REQ-015 SHALL have port instr_pc  output  32: head instruction address.

Function
REQ-016 SHALL hold fetch_pc; imem_addr = fetch_pc; fetch_pc += 4 on each accepted request (valid & ready), mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 SHALL run a request FSM with states IDLE (none outstanding), WAIT (one live outstanding), STALE (one outstanding to discard); at most one outstanding request at any time.
REQ-018 SHALL define push = imem_rsp_valid & (state==WAIT) & !pcSrc, pop = instr_valid & instr_ready, and assert imem_req_valid iff !rst & (state==IDLE | imem_rsp_valid) & (count + push - pop < FIFO_DEPTH).
REQ-019 SHALL move IDLE->WAIT on acceptance without pcSrc; IDLE->STALE on acceptance with pcSrc; WAIT/STALE->IDLE on response without new acceptance; WAIT/STALE->WAIT (or STALE if pcSrc) on response plus new acceptance; WAIT->STALE on pcSrc with no response.
REQ-020 SHALL write {fetch address, imem_rsp_data} to the FIFO tail on push; entries become visible on instr/instr_pc the cycle after push (no bypass).
REQ-021 SHALL drop a response received in STALE, or in WAIT with pcSrc the same cycle, without writing the FIFO.
REQ-022 SHALL, on pcSrc: set fetch_pc = {pcBranch[31:2], 2'b00}, flush all FIFO entries at the edge after any same-cycle pop, and treat any request accepted that cycle as stale.
REQ-023 SHALL complete a pop (instr_ready & instr_valid) in the same cycle as pcSrc; the popped instruction counts as consumed.
REQ-024 SHALL hold instr/instr_pc stable while instr_valid & !instr_ready and no pcSrc.
REQ-025 SHALL support simultaneous push and pop when full; count unchanged, order preserved.
REQ-026 SHALL ignore imem_rsp_valid in IDLE (protocol error, no FIFO write, no state change).
REQ-027 SHALL sustain one instruction per cycle with 1-cycle memory latency and instr_ready held high.

Reset
REQ-028 SHALL, while rst is high: fetch_pc = RESET_PC, state = IDLE, FIFO empty; imem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-029 SHALL, when rst is asserted mid-operation, discard outstanding requests, any responses in the rst cycle, and FIFO contents; the first request after rst falls is to RESET_PC.

Verification
REQ-030 Reset release, ready=1, 1-cycle latency, instr_ready=1 -> addr 0 in cycle 0, addr 4 in cycle 1, instr_valid with instr_pc=0 in cycle 2, then pc 4, 8, ... every cycle.
REQ-031 instr_ready=0 for 10 cycles -> FIFO fills to FIFO_DEPTH, imem_req_valid drops, instr/instr_pc=0 held stable; on release, pcs 0, 4 delivered in order with no gaps or duplicates.
REQ-032 pcSrc=1, pcBranch=32'h0000_0103, one request outstanding -> response dropped, FIFO empty next cycle, next imem_addr=32'h0000_0100, first delivered instr_pc=32'h100.
REQ-033 pcSrc coincident with imem_rsp_valid and pop -> popped entry consumed, response not written, instr_valid=0 next cycle.
REQ-034 Random imem_req_ready/latency (1-5 cycles) and instr_ready, with random redirects -> instr_pc sequence always matches the reference PC model; never more than one outstanding request.
REQ-035 fetch_pc=32'hFFFF_FFFC via redirect -> next request address 0.
